// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave):
// req/ready request handshake plus an rvalid read-return strobe.
interface mem_access_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [3:0]        dmem_wmask;
    logic              dmem_ready;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory stage: issues data-memory requests, steers store lanes, aligns and
// extends loads, and holds the MEM/WB register consumed by writeback.
module mem_access_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_reg_write,
    input  logic [2:0]            ex_funct3,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [4:0]            ex_rd,
    output logic                  mem_stall,
    mem_access_stage_if.master    dmem,
    output logic                  wb_valid,
    output logic                  mem_read,
    output logic                  reg_write,
    output logic [XLEN-1:0]       mem_data_out,
    output logic [XLEN-1:0]       alu_result,
    output logic [4:0]            wb_rd,
    output logic                  misaligned
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, sdata_q, sdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic            load_q, load_d, rw_q, rw_d;

    logic            wbv_q, wbv_d, wbmr_q, wbmr_d, wbrw_q, wbrw_d, wbmis_q, wbmis_d;
    logic [XLEN-1:0] wbdata_q, wbdata_d, wbalu_q, wbalu_d;
    logic [4:0]      wbrd_q, wbrd_d;

    logic            ex_mem, ex_mis, start;
    logic [XLEN-1:0] st_wdata, ld_data;
    logic [3:0]      st_wmask;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign ex_mem    = ex_mem_read | ex_mem_write;
    assign ex_mis    = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                       ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
    assign start     = (state_q == S_IDLE) && ex_valid && ex_mem && !ex_mis;
    assign mem_stall = (state_q != S_IDLE) || start;

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                st_wdata = {4{sdata_q[7:0]}};
                st_wmask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_wdata = {2{sdata_q[15:0]}};
                st_wmask = 4'b0011 << addr_q[1:0];
            end
            default: begin
                st_wdata = sdata_q;
                st_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem.dmem_rdata;
        endcase
    end

    assign dmem.dmem_req   = (state_q == S_REQ);
    assign dmem.dmem_we    = (state_q == S_REQ) && !load_q;
    assign dmem.dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_wdata = st_wdata;
    assign dmem.dmem_wmask = ((state_q == S_REQ) && !load_q) ? st_wmask : '0;

    // MEM/WB control bits default to a bubble each cycle; data fields hold.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sdata_d  = sdata_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        load_d   = load_q;
        rw_d     = rw_q;
        wbv_d    = 1'b0;
        wbmr_d   = 1'b0;
        wbrw_d   = 1'b0;
        wbmis_d  = 1'b0;
        wbdata_d = wbdata_q;
        wbalu_d  = wbalu_q;
        wbrd_d   = wbrd_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!ex_mem || ex_mis) begin
                        wbv_d   = 1'b1;
                        wbrw_d  = ex_reg_write && !ex_mem;
                        wbmis_d = ex_mem;
                        wbalu_d = ex_alu_result;
                        wbrd_d  = ex_rd;
                    end else begin
                        addr_d  = ex_alu_result;
                        sdata_d = ex_store_data;
                        f3_d    = ex_funct3;
                        rd_d    = ex_rd;
                        load_d  = ex_mem_read;
                        rw_d    = ex_reg_write;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem.dmem_ready) begin
                    if (load_q) begin
                        state_d = S_WAIT;
                    end else begin
                        wbv_d   = 1'b1;
                        wbalu_d = addr_q;
                        wbrd_d  = rd_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    wbv_d    = 1'b1;
                    wbmr_d   = 1'b1;
                    wbrw_d   = rw_q;
                    wbdata_d = ld_data;
                    wbalu_d  = addr_q;
                    wbrd_d   = rd_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            sdata_q  <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            load_q   <= 1'b0;
            rw_q     <= 1'b0;
            wbv_q    <= 1'b0;
            wbmr_q   <= 1'b0;
            wbrw_q   <= 1'b0;
            wbmis_q  <= 1'b0;
            wbdata_q <= '0;
            wbalu_q  <= '0;
            wbrd_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            load_q   <= load_d;
            rw_q     <= rw_d;
            wbv_q    <= wbv_d;
            wbmr_q   <= wbmr_d;
            wbrw_q   <= wbrw_d;
            wbmis_q  <= wbmis_d;
            wbdata_q <= wbdata_d;
            wbalu_q  <= wbalu_d;
            wbrd_q   <= wbrd_d;
        end
    end

    assign wb_valid     = wbv_q;
    assign mem_read     = wbmr_q;
    assign reg_write    = wbrw_q;
    assign misaligned   = wbmis_q;
    assign mem_data_out = wbdata_q;
    assign alu_result   = wbalu_q;
    assign wb_rd        = wbrd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized instruction/memory
// traffic, checked every cycle against a transaction-level model.
module tb_mem_access_stage;
    typedef struct packed {
        logic        v, ld, st, rw;
        logic [2:0]  f3;
        logic [31:0] alu, sd;
        logic [4:0]  rd;
    } ins_t;

    typedef struct packed {
        logic        has, acc, ld, rw;
        logic [2:0]  f3;
        logic [31:0] addr, data;
        logic [4:0]  rd;
    } pend_t;

    logic        i_clk, i_rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_stall, wb_valid, mem_read, reg_write, misaligned;
    logic [31:0] mem_data_out, alu_result;
    logic [4:0]  wb_rd;

    mem_access_stage_if #(.XLEN(32), .ADDR_W(32)) bus ();

    mem_access_stage #(.XLEN(32), .ADDR_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .mem_stall(mem_stall), .dmem(bus),
        .wb_valid(wb_valid), .mem_read(mem_read), .reg_write(reg_write),
        .mem_data_out(mem_data_out), .alu_result(alu_result), .wb_rd(wb_rd),
        .misaligned(misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pend_t       p;
    logic        e_wbv, e_mr, e_rw, e_mis;
    logic [31:0] e_data, e_alu;
    logic [4:0]  e_rd;
    logic        last_consumed;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'd0:    return 32'(1 << (a % 4));
            2'd1:    return 32'(3 << (a % 4));
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return (d & 32'hFF) * 32'h0101_0101;
            2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f3)
            3'd0:    return (v & 32'h80) != 0 ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
            3'd1:    return (v & 32'h8000) != 0 ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic ins_t mk(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
        ins_t r;
        r.v = 1'b1; r.ld = ld; r.st = st; r.rw = rw; r.f3 = f3;
        r.alu = alu; r.sd = sd; r.rd = rd;
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r;
        int unsigned k;
        r = '0;
        r.v   = ($urandom_range(0, 4) != 0);
        k     = $urandom_range(0, 5);
        r.ld  = (k == 2 || k == 3 || k == 5);
        r.st  = (k == 4 || k == 5);
        r.rw  = 1'($urandom_range(0, 1));
        r.rd  = 5'($urandom);
        r.sd  = $urandom;
        r.alu = $urandom;
        if (r.st && !r.ld) r.f3 = 3'($urandom_range(0, 2));
        else begin
            case ($urandom_range(0, 4))
                0: r.f3 = 3'd0;
                1: r.f3 = 3'd1;
                2: r.f3 = 3'd2;
                3: r.f3 = 3'd4;
                default: r.f3 = 3'd5;
            endcase
        end
        if ($urandom_range(0, 3) != 0) begin
            if (r.f3[1:0] == 2'd2) r.alu[1:0] = 2'b00;
            else if (r.f3[1:0] == 2'd1) r.alu[0] = 1'b0;
        end
        return r;
    endfunction

    // One clock cycle: drive at the negedge, check combinational outputs, advance the
    // model across the posedge, then check the MEM/WB outputs.
    task automatic step(input ins_t i, input logic rdy, input logic rv, input logic [31:0] rdat);
        logic mem, mis;
        ex_valid = i.v; ex_mem_read = i.ld; ex_mem_write = i.st; ex_reg_write = i.rw;
        ex_funct3 = i.f3; ex_alu_result = i.alu; ex_store_data = i.sd; ex_rd = i.rd;
        bus.dmem_ready = rdy; bus.dmem_rvalid = rv; bus.dmem_rdata = rdat;
        #1;
        mem = i.v && (i.ld || i.st);
        mis = is_mis(i.f3, i.alu);
        chk("mem_stall", 32'(mem_stall), 32'(p.has || (mem && !mis)));
        if (p.has && !p.acc) begin
            chk("dmem_req", 32'(bus.dmem_req), 32'd1);
            chk("dmem_we", 32'(bus.dmem_we), 32'(!p.ld));
            chk("dmem_addr", bus.dmem_addr, p.addr & 32'hFFFF_FFFC);
            chk("dmem_wmask", 32'(bus.dmem_wmask), p.ld ? 32'd0 : exp_mask(p.f3, p.addr));
            if (!p.ld) chk("dmem_wdata", bus.dmem_wdata, exp_wdata(p.f3, p.data));
        end else begin
            chk("dmem_req_idle", 32'(bus.dmem_req), 32'd0);
            chk("dmem_wmask_idle", 32'(bus.dmem_wmask), 32'd0);
        end
        @(posedge i_clk);
        last_consumed = 1'b0;
        e_wbv = 1'b0; e_mr = 1'b0; e_rw = 1'b0; e_mis = 1'b0;
        if (!p.has) begin
            if (i.v) begin
                last_consumed = 1'b1;
                if (!mem) begin
                    e_wbv = 1'b1; e_rw = i.rw; e_alu = i.alu; e_rd = i.rd;
                end else if (mis) begin
                    e_wbv = 1'b1; e_mis = 1'b1; e_alu = i.alu; e_rd = i.rd;
                end else begin
                    p.has = 1'b1; p.acc = 1'b0; p.ld = i.ld; p.rw = i.rw; p.f3 = i.f3;
                    p.addr = i.alu; p.data = i.sd; p.rd = i.rd;
                end
            end
        end else if (!p.acc) begin
            if (rdy) begin
                if (p.ld) p.acc = 1'b1;
                else begin
                    e_wbv = 1'b1; e_alu = p.addr; e_rd = p.rd; p.has = 1'b0;
                end
            end
        end else if (rv) begin
            e_wbv = 1'b1; e_mr = 1'b1; e_rw = p.rw; e_data = ld_fmt(p.f3, p.addr, rdat);
            e_alu = p.addr; e_rd = p.rd; p.has = 1'b0;
        end
        #1;
        chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
        chk("reg_write", 32'(reg_write), 32'(e_rw));
        chk("mem_read", 32'(mem_read), 32'(e_mr));
        chk("misaligned", 32'(misaligned), 32'(e_mis));
        chk("mem_data_out", mem_data_out, e_data);
        chk("alu_result", alu_result, e_alu);
        chk("wb_rd", 32'(wb_rd), 32'(e_rd));
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0;
        i_rst = 1'b1;
        #1;
        p = '0;
        e_wbv = 1'b0; e_mr = 1'b0; e_rw = 1'b0; e_mis = 1'b0;
        e_data = '0; e_alu = '0; e_rd = '0;
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
        chk("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
        chk("rst_dmem_wmask", 32'(bus.dmem_wmask), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_data_out", mem_data_out, 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t nop, cur;
        logic [5:0] wbv_hist;
        logic rdy, rv;
        nop = '0;
        i_rst = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        ex_funct3 = '0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
        bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        #1;
        do_reset();

        // ALU op retires after one cycle without stalling
        step(mk(0, 0, 1, 3'd0, 32'h0000_1234, 32'h0, 5'd5), 0, 0, 0);
        chk("add_wb_valid", 32'(wb_valid), 32'd1);
        chk("add_reg_write", 32'(reg_write), 32'd1);
        chk("add_alu_result", alu_result, 32'h0000_1234);
        chk("add_wb_rd", 32'(wb_rd), 32'd5);

        // SB to 0x103, memory ready after two request cycles
        step(mk(0, 1, 1, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd7), 0, 0, 0);
        step(nop, 0, 0, 0);
        chk("sb_addr", bus.dmem_addr, 32'h0000_0100);
        chk("sb_wmask", 32'(bus.dmem_wmask), 32'h8);
        chk("sb_wdata", bus.dmem_wdata, 32'hDDDD_DDDD);
        step(nop, 0, 0, 0);
        step(nop, 1, 0, 0);
        chk("sb_retire", 32'(wb_valid), 32'd1);
        chk("sb_reg_write", 32'(reg_write), 32'd0);

        // LH / LHU from 0x102, rvalid three cycles after accept
        for (int k = 0; k < 2; k++) begin
            step(mk(1, 0, 1, (k == 0) ? 3'd1 : 3'd5, 32'h0000_0102, 32'h0, 5'd9), 0, 0, 0);
            step(nop, 1, 0, 0);
            step(nop, 0, 0, 0);
            step(nop, 0, 0, 0);
            step(nop, 0, 1, 32'h8001_7FFF);
            chk(k == 0 ? "lh_data" : "lhu_data", mem_data_out, k == 0 ? 32'hFFFF_8001 : 32'h0000_8001);
            chk("lh_mem_read", 32'(mem_read), 32'd1);
        end

        // Misaligned LW: no request, immediate retire flagged misaligned
        step(mk(1, 0, 1, 3'd2, 32'h0000_0101, 32'h0, 5'd3), 0, 0, 0);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_reg_write", 32'(reg_write), 32'd0);
        step(nop, 0, 0, 0);
        chk("mis_pulse", 32'(misaligned), 32'd0);

        // Reset while waiting for read data; late rvalid must not retire
        step(mk(1, 0, 1, 3'd2, 32'h0000_0200, 32'h0, 5'd4), 0, 0, 0);
        step(nop, 1, 0, 0);
        do_reset();
        step(nop, 0, 1, 32'hDEAD_BEEF);
        chk("late_rvalid", 32'(wb_valid), 32'd0);

        // Back-to-back LW with a held second instruction
        step(mk(1, 0, 1, 3'd2, 32'h0000_0300, 32'h0, 5'd1), 0, 0, 0);
        wbv_hist[0] = wb_valid;
        step(mk(1, 0, 1, 3'd2, 32'h0000_0304, 32'h0, 5'd2), 1, 0, 0);
        wbv_hist[1] = wb_valid;
        step(mk(1, 0, 1, 3'd2, 32'h0000_0304, 32'h0, 5'd2), 0, 1, 32'h1111_2222);
        wbv_hist[2] = wb_valid;
        chk("b2b_data1", mem_data_out, 32'h1111_2222);
        chk("b2b_rd1", 32'(wb_rd), 32'd1);
        step(mk(1, 0, 1, 3'd2, 32'h0000_0304, 32'h0, 5'd2), 0, 0, 0);
        wbv_hist[3] = wb_valid;
        step(nop, 1, 0, 0);
        wbv_hist[4] = wb_valid;
        step(nop, 0, 1, 32'h3333_4444);
        wbv_hist[5] = wb_valid;
        chk("b2b_data2", mem_data_out, 32'h3333_4444);
        chk("b2b_rd2", 32'(wb_rd), 32'd2);
        chk("b2b_wbv_pattern", 32'(wbv_hist), 32'b100100);

        // Randomized traffic; execute holds an instruction until the stage takes it
        cur = rnd_ins();
        for (int c = 0; c < 3000; c++) begin
            rdy = 1'($urandom_range(0, 1));
            rv  = p.acc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            step(cur, rdy, rv, $urandom);
            if (last_consumed || !cur.v) cur = rnd_ins();
            if (c == 1500) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
